// File: rtl/spi_packet_rx.sv
// SPI slave receiver: synchronizes sck/sdi/cs into clk_sys domain and assembles 16-bit frames.
// Optional idle timeout on stalled partial frames is enabled with `define SPI_TIMEOUT_EN.
module spi_packet_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    input  logic       cs,
    output logic       ready,
    output logic [7:0] spiPacket1,
    output logic [7:0] spiPacket2,
    output logic       frameErr
);

    // state | meaning
    // IDLE  | synced cs high, no frame in progress
    // SHIFT | synced cs low, sampling sdi on each sck rising edge
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic        sck_s1, sck_s2, sck_s3;
    logic        cs_s1, cs_s2;
    logic        sdi_s1, sdi_s2;
    logic        sck_rise;
    logic        shift_en;
    logic        abort;
    logic        timeout;
    logic [3:0]  bit_cnt;
    logic [15:0] shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_s3 <= 1'b0;
            cs_s1  <= 1'b1;
            cs_s2  <= 1'b1;
            sdi_s1 <= 1'b0;
            sdi_s2 <= 1'b0;
        end else begin
            sck_s1 <= sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            cs_s1  <= cs;
            cs_s2  <= cs_s1;
            sdi_s1 <= sdi;
            sdi_s2 <= sdi_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!cs_s2) state_nxt = SHIFT;
            SHIFT:   if (cs_s2)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A sck edge coincident with cs deassert is dropped: deassert wins.
    always_comb begin
        shift_en = 1'b0;
        abort    = 1'b0;
        if (state == SHIFT) begin
            shift_en = !cs_s2 && sck_rise && !timeout;
            abort    = (cs_s2 && (bit_cnt != 4'd0)) || timeout;
        end
    end

`ifdef SPI_TIMEOUT_EN
    logic [7:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= 8'd0;
        else if (state != SHIFT || bit_cnt == 4'd0 || sck_rise || timeout)
            idle_cnt <= 8'd0;
        else
            idle_cnt <= idle_cnt + 8'd1;
    end

    assign timeout = (idle_cnt == 8'hFF);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 4'd0;
            shreg      <= 16'h0000;
            ready      <= 1'b0;
            frameErr   <= 1'b0;
            spiPacket1 <= 8'h00;
            spiPacket2 <= 8'h00;
        end else begin
            ready    <= 1'b0;
            frameErr <= 1'b0;
            if (abort) begin
                bit_cnt  <= 4'd0;
                frameErr <= 1'b1;
            end else if (shift_en) begin
                shreg   <= {shreg[14:0], sdi_s2};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd15) begin
                    ready      <= 1'b1;
                    spiPacket1 <= shreg[14:7];
                    spiPacket2 <= {shreg[6:0], sdi_s2};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_packet_rx.sv
// Self-checking bench for spi_packet_rx; expected frames go to a scoreboard queue as they are sent.
// Expectations for the stalled-frame scenario follow `define SPI_TIMEOUT_EN.
module tb_spi_packet_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sck = 1'b0;
    logic       sdi = 1'b0;
    logic       cs = 1'b1;
    logic       ready;
    logic [7:0] spiPacket1;
    logic [7:0] spiPacket2;
    logic       frameErr;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          err_cnt = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    spi_packet_rx dut (
        .clk(clk),
        .reset(reset),
        .sck(sck),
        .sdi(sdi),
        .cs(cs),
        .ready(ready),
        .spiPacket1(spiPacket1),
        .spiPacket2(spiPacket2),
        .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    // Monitor: every ready cycle is one observed frame, every frameErr cycle one error.
    always @(negedge clk) begin
        if (!reset) begin
            if (ready)    obs_q.push_back({spiPacket1, spiPacket2});
            if (frameErr) err_cnt++;
        end
    end

    task automatic send_bit(input logic b);
        sdi = b;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b);
        exp_q.push_back({a, b});
        send_byte(a);
        send_byte(b);
    endtask

    task automatic cs_low;
        sck = 1'b0;
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high;
        cs = 1'b1;
        repeat (6) @(negedge clk);
        sck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt += 4;
        if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready);
        else pass_cnt++;
        if (frameErr !== 1'b0) $display("FAIL reset_frameErr got %b exp 0", frameErr);
        else pass_cnt++;
        if (spiPacket1 !== 8'h00) $display("FAIL reset_p1 got %h exp 00", spiPacket1);
        else pass_cnt++;
        if (spiPacket2 !== 8'h00) $display("FAIL reset_p2 got %h exp 00", spiPacket2);
        else pass_cnt++;
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame;
        logic [15:0] e, o;
        int err0;
        err0 = err_cnt;
        cs_low();
        send_frame(8'hE5, 8'h12);
        cs_high();
        total_cnt += 3;
        if (obs_q.size() !== 1) $display("FAIL frame_count got %0d exp 1", obs_q.size());
        else pass_cnt++;
        if (err_cnt - err0 !== 0) $display("FAIL frame_err got %0d exp 0", err_cnt - err0);
        else pass_cnt++;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
        if (o !== e) $display("FAIL frame_data got %h exp %h", o, e);
        else pass_cnt++;
    endtask

    task automatic test_partial;
        int err0;
        err0 = err_cnt;
        cs_low();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        cs_high();
        total_cnt += 4;
        if (obs_q.size() !== 0) $display("FAIL partial_ready got %0d exp 0", obs_q.size());
        else pass_cnt++;
        if (err_cnt - err0 !== 1) $display("FAIL partial_err got %0d exp 1", err_cnt - err0);
        else pass_cnt++;
        if (spiPacket1 !== 8'hE5) $display("FAIL partial_p1_hold got %h exp e5", spiPacket1);
        else pass_cnt++;
        if (spiPacket2 !== 8'h12) $display("FAIL partial_p2_hold got %h exp 12", spiPacket2);
        else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [15:0] e, o;
        int err0;
        err0 = err_cnt;
        cs_low();
        send_frame(8'h10, 8'h20);
        send_frame(8'h30, 8'h40);
        cs_high();
        total_cnt += 4;
        if (obs_q.size() !== 2) $display("FAIL b2b_count got %0d exp 2", obs_q.size());
        else pass_cnt++;
        if (err_cnt - err0 !== 0) $display("FAIL b2b_err got %0d exp 0", err_cnt - err0);
        else pass_cnt++;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
        if (o !== e) $display("FAIL b2b_first got %h exp %h", o, e);
        else pass_cnt++;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
        if (o !== e) $display("FAIL b2b_second got %h exp %h", o, e);
        else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [15:0] e, o;
        int err0;
        err0 = err_cnt;
        cs_low();
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt += 4;
        if (ready !== 1'b0) $display("FAIL rstmid_ready got %b exp 0", ready);
        else pass_cnt++;
        if (frameErr !== 1'b0) $display("FAIL rstmid_frameErr got %b exp 0", frameErr);
        else pass_cnt++;
        if (spiPacket1 !== 8'h00) $display("FAIL rstmid_p1 got %h exp 00", spiPacket1);
        else pass_cnt++;
        if (spiPacket2 !== 8'h00) $display("FAIL rstmid_p2 got %h exp 00", spiPacket2);
        else pass_cnt++;
        cs = 1'b1;
        sck = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        cs_low();
        send_frame(8'hA0, 8'h05);
        cs_high();
        total_cnt += 3;
        if (err_cnt - err0 !== 0) $display("FAIL rstmid_err got %0d exp 0", err_cnt - err0);
        else pass_cnt++;
        if (obs_q.size() !== 1) $display("FAIL rstmid_count got %0d exp 1", obs_q.size());
        else pass_cnt++;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
        if (o !== e) $display("FAIL rstmid_data got %h exp %h", o, e);
        else pass_cnt++;
        obs_q.delete();
    endtask

    task automatic test_stall;
        logic [15:0] e, o;
        int err0;
        int exp_stall_err;
`ifdef SPI_TIMEOUT_EN
        exp_stall_err = 1;
`else
        exp_stall_err = 0;
`endif
        err0 = err_cnt;
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        repeat (300) @(negedge clk);
        total_cnt += 2;
        if (err_cnt - err0 !== exp_stall_err)
            $display("FAIL stall_err got %0d exp %0d", err_cnt - err0, exp_stall_err);
        else pass_cnt++;
        if (obs_q.size() !== 0) $display("FAIL stall_ready got %0d exp 0", obs_q.size());
        else pass_cnt++;
        cs_high();
        total_cnt += 1;
        if (err_cnt - err0 !== 1) $display("FAIL stall_err_total got %0d exp 1", err_cnt - err0);
        else pass_cnt++;
        cs_low();
        send_frame(8'h33, 8'h44);
        cs_high();
        total_cnt += 2;
        if (obs_q.size() !== 1) $display("FAIL stall_next_count got %0d exp 1", obs_q.size());
        else pass_cnt++;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
        if (o !== e) $display("FAIL stall_next_data got %h exp %h", o, e);
        else pass_cnt++;
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_partial();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spi_packet_rx.md
SPI_PACKET_RX -- requirements
Module: spi_packet_rx

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL provide port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL provide port sck, input, 1, SPI serial clock from the MCU, asynchronous to clk.
REQ-005 The block SHALL provide port sdi, input, 1, SPI serial data from the MCU, asynchronous to clk.
REQ-006 The block SHALL provide port cs, input, 1, active-low chip select, asynchronous to clk.
REQ-007 The block SHALL provide port ready, output, 1, one-cycle pulse when a complete 16-bit frame is received.
REQ-008 The block SHALL provide port spiPacket1, output, 8, first received byte of the last complete frame.
REQ-009 The block SHALL provide port spiPacket2, output, 8, second received byte of the last complete frame.
REQ-010 The block SHALL provide port frameErr, output, 1, one-cycle pulse when a partial frame is discarded.

Function
REQ-011 sck, sdi and cs SHALL each pass through a 2-flop synchronizer; a third sck flop SHALL form a rising-edge detect (sckRise).
REQ-012 The FSM SHALL have states IDLE (synced cs high) and SHIFT (synced cs low); IDLE->SHIFT on synced cs low, SHIFT->IDLE on synced cs high.
REQ-013 In SHIFT, on each sckRise the synced sdi SHALL shift into a 16-bit shift register, MSB first, and a 4-bit bit counter SHALL increment.
REQ-014 On the sckRise that completes bit 16 (counter 15->0 wrap), the following cycle SHALL load spiPacket1 = bits[15:8] and spiPacket2 = bits[7:0] together and assert ready for exactly one clk cycle.
REQ-015 spiPacket1/spiPacket2 SHALL hold their values between completed frames; ready SHALL never assert for a partial frame.
REQ-016 More than 16 edges within one cs assertion SHALL be treated as back-to-back frames; each further 16 bits produce another ready pulse.
REQ-017 Synced cs rising with bit counter nonzero SHALL clear the counter, leave outputs unchanged, and pulse frameErr for one cycle; counter zero SHALL produce no frameErr.
REQ-018 A sckRise in the same cycle as synced cs rising SHALL be ignored (deassert wins).
REQ-019 Correct operation SHALL require sck high and low phases each of at least 3 clk periods; faster sck is out of specification.
REQ-020 Latency from the 16th sck rising edge at the pin to ready SHALL be at most 4 clk cycles.

Reset
REQ-021 reset SHALL asynchronously force state IDLE, bit counter 0, shift register 0x0000, synchronizer flops to idle levels (sck 0, cs 1, sdi 0), ready 0, frameErr 0, spiPacket1 0x00, spiPacket2 0x00.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame with no ready or frameErr pulse; after release, reception restarts from bit 0 on the next cs assertion.

Configuration
REQ-023 With macro SPI_TIMEOUT_EN defined, an 8-bit idle counter SHALL count clk cycles in SHIFT with bit counter nonzero and no sckRise, clearing on each sckRise; on reaching 255 the partial frame SHALL be discarded as in REQ-017 (frameErr pulse, counter cleared, outputs unchanged).
REQ-024 Without SPI_TIMEOUT_EN, no idle counter SHALL exist and a stalled partial frame SHALL persist until cs deasserts or reset.

Verification
REQ-025 cs low, send 0xE5 then 0x12, cs high -> one ready pulse, spiPacket1=0xE5, spiPacket2=0x12, frameErr never high.
REQ-026 cs low, send 10 bits, cs high -> frameErr pulse once, no ready, spiPacket1/2 keep previous 0xE5/0x12.
REQ-027 cs low, send 0x10,0x20,0x30,0x40 continuously, cs high -> two ready pulses; first 0x10/0x20, second 0x30/0x40.
REQ-028 Assert reset after 12 bits of a frame -> all outputs 0 immediately; next full frame 0xA0,0x05 -> ready, spiPacket1=0xA0, spiPacket2=0x05.
REQ-029 SPI_TIMEOUT_EN defined: cs low, 5 bits, hold sck 300 clk cycles -> frameErr pulse near cycle 255, no ready; then cs high/low and frame 0x33,0x44 -> ready with 0x33/0x44.
REQ-030 SPI_TIMEOUT_EN undefined: same stimulus as REQ-029 -> no frameErr until cs deasserts, then exactly one frameErr pulse.
